// File: rtl/daq_gtx_pkg.sv
// Shared constants and state encoding for the DAQ GTX framer.
// 8b/10b control words are 16-bit with a per-byte K flag.
package daq_gtx_pkg;

   localparam logic [15:0] K_IDLE  = 16'h50BC;
   localparam logic [15:0] K_SOF   = 16'h55FB;
   localparam logic [15:0] K_EOF   = 16'hF7FD;

   localparam logic [1:0]  KI_IDLE = 2'b01;
   localparam logic [1:0]  KI_SOF  = 2'b01;
   localparam logic [1:0]  KI_EOF  = 2'b11;
   localparam logic [1:0]  KI_DATA = 2'b00;

   typedef enum logic [2:0] {
      ST_READY,
      ST_SOF,
      ST_DATA,
      ST_EOF,
      ST_GAP
   } state_t;

endpackage

// File: rtl/daq_gtx_framer.sv
// Frames the readout packet stream with SOF/EOF/IDLE K-words for the GTX,
// enforcing an idle gap and checking packet length.
module daq_gtx_framer
   import daq_gtx_pkg::*;
#(
   parameter int PKT_WORDS = 100,
   parameter int MIN_IDLE  = 6
) (
   input  logic        RCLK,
   input  logic        RST,
   input  logic        TX_EN,
   input  logic [15:0] TXD,
   input  logic        TXD_VLD,
   output logic        TXACK,
   output logic [15:0] GTX_TXDATA,
   output logic [1:0]  GTX_TXCHARISK,
   output logic        BUSY,
   output logic [15:0] PKT_CNT,
   output logic        LEN_ERR,
   output logic [7:0]  LEN_ERR_CNT
);

   state_t      state_q, state_d;
   logic [7:0]  gap_q, gap_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [15:0] hold_q, hold_d;
   logic [15:0] data_q, data_d;
   logic [1:0]  k_q, k_d;
   logic        ack_q, ack_d;
   logic        busy_q, busy_d;
   logic [15:0] pkt_cnt_q, pkt_cnt_d;
   logic        lerr_q, lerr_d;
   logic [7:0]  lcnt_q, lcnt_d;

   always_comb begin
      state_d   = state_q;
      gap_d     = gap_q;
      cnt_d     = cnt_q;
      hold_d    = hold_q;
      data_d    = K_IDLE;
      k_d       = KI_IDLE;
      ack_d     = 1'b0;
      busy_d    = busy_q;
      pkt_cnt_d = pkt_cnt_q;
      lerr_d    = 1'b0;
      lcnt_d    = lcnt_q;
      unique case (state_q)
         ST_GAP: begin
            gap_d = gap_q - 8'd1;
            if (gap_q <= 8'd1) begin
               gap_d   = 8'd0;
               state_d = ST_READY;
            end
         end
         ST_READY: begin
            busy_d = 1'b0;
            ack_d  = TX_EN;
            // Valid data starts a packet even when TX_EN is low
            if (TXD_VLD) begin
               data_d  = K_SOF;
               k_d     = KI_SOF;
               hold_d  = TXD;
               cnt_d   = 8'd1;
               ack_d   = 1'b0;
               busy_d  = 1'b1;
               state_d = ST_SOF;
            end
         end
         ST_SOF, ST_DATA: begin
            data_d = hold_q;
            k_d    = KI_DATA;
            if (TXD_VLD) begin
               hold_d  = TXD;
               cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
               state_d = ST_DATA;
            end else begin
               state_d = ST_EOF;
            end
         end
         ST_EOF: begin
            data_d    = K_EOF;
            k_d       = KI_EOF;
            pkt_cnt_d = pkt_cnt_q + 16'd1;
            if (int'(cnt_q) != PKT_WORDS) begin
               lerr_d = 1'b1;
               lcnt_d = (lcnt_q == 8'hFF) ? lcnt_q : lcnt_q + 8'd1;
            end
            gap_d   = 8'(MIN_IDLE);
            state_d = ST_GAP;
         end
         default: state_d = ST_GAP;
      endcase
   end

   always_ff @(posedge RCLK or posedge RST) begin
      if (RST) begin
         state_q   <= ST_GAP;
         gap_q     <= 8'(MIN_IDLE);
         cnt_q     <= 8'd0;
         hold_q    <= 16'd0;
         data_q    <= K_IDLE;
         k_q       <= KI_IDLE;
         ack_q     <= 1'b0;
         busy_q    <= 1'b0;
         pkt_cnt_q <= 16'd0;
         lerr_q    <= 1'b0;
         lcnt_q    <= 8'd0;
      end else begin
         state_q   <= state_d;
         gap_q     <= gap_d;
         cnt_q     <= cnt_d;
         hold_q    <= hold_d;
         data_q    <= data_d;
         k_q       <= k_d;
         ack_q     <= ack_d;
         busy_q    <= busy_d;
         pkt_cnt_q <= pkt_cnt_d;
         lerr_q    <= lerr_d;
         lcnt_q    <= lcnt_d;
      end
   end

   assign TXACK         = ack_q;
   assign GTX_TXDATA    = data_q;
   assign GTX_TXCHARISK = k_q;
   assign BUSY          = busy_q;
   assign PKT_CNT       = pkt_cnt_q;
   assign LEN_ERR       = lerr_q;
   assign LEN_ERR_CNT   = lcnt_q;

endmodule

// File: tb/tb_daq_gtx_framer.sv
// Randomized self-checking bench for daq_gtx_framer against a
// frame-level reference model (SOF, payload, EOF, idle gap).
module tb_daq_gtx_framer;
   import daq_gtx_pkg::*;

   localparam int PKT_WORDS = 100;
   localparam int MIN_IDLE  = 6;

   logic        RCLK = 1'b0;
   logic        RST;
   logic        TX_EN;
   logic [15:0] TXD;
   logic        TXD_VLD;
   logic        TXACK;
   logic [15:0] GTX_TXDATA;
   logic [1:0]  GTX_TXCHARISK;
   logic        BUSY;
   logic [15:0] PKT_CNT;
   logic        LEN_ERR;
   logic [7:0]  LEN_ERR_CNT;

   daq_gtx_framer #(.PKT_WORDS(PKT_WORDS), .MIN_IDLE(MIN_IDLE)) dut (
      .RCLK(RCLK), .RST(RST), .TX_EN(TX_EN), .TXD(TXD), .TXD_VLD(TXD_VLD),
      .TXACK(TXACK), .GTX_TXDATA(GTX_TXDATA), .GTX_TXCHARISK(GTX_TXCHARISK),
      .BUSY(BUSY), .PKT_CNT(PKT_CNT), .LEN_ERR(LEN_ERR),
      .LEN_ERR_CNT(LEN_ERR_CNT)
   );

   always #5 RCLK = ~RCLK;

   int checks = 0;
   int fails  = 0;
   int m_pkt  = 0;
   int m_lerr = 0;

   logic [15:0] obs_d[$];
   logic [1:0]  obs_k[$];
   logic        obs_le[$];
   logic        obs_ack[$];
   logic        obs_busy[$];

   logic [15:0] pay[$];
   logic [15:0] exp_d[$];
   logic [1:0]  exp_k[$];
   logic        exp_le[$];

   // Output monitor: one sample per cycle, away from the active edge
   always @(negedge RCLK) begin
      obs_d.push_back(GTX_TXDATA);
      obs_k.push_back(GTX_TXCHARISK);
      obs_le.push_back(LEN_ERR);
      obs_ack.push_back(TXACK);
      obs_busy.push_back(BUSY);
   end

   task automatic clear_obs();
      obs_d.delete(); obs_k.delete(); obs_le.delete();
      obs_ack.delete(); obs_busy.delete();
   endtask

   function automatic int find_sym(logic [15:0] w, logic [1:0] k, int from);
      for (int i = from; i < obs_d.size(); i++)
         if (obs_d[i] === w && obs_k[i] === k) return i;
      return -1;
   endfunction

   function automatic logic [15:0] get_d(int i);
      return (i >= 0 && i < obs_d.size()) ? obs_d[i] : 16'hxxxx;
   endfunction
   function automatic logic [1:0] get_k(int i);
      return (i >= 0 && i < obs_k.size()) ? obs_k[i] : 2'bxx;
   endfunction
   function automatic logic get_le(int i);
      return (i >= 0 && i < obs_le.size()) ? obs_le[i] : 1'bx;
   endfunction
   function automatic logic get_ack(int i);
      return (i >= 0 && i < obs_ack.size()) ? obs_ack[i] : 1'bx;
   endfunction
   function automatic logic get_busy(int i);
      return (i >= 0 && i < obs_busy.size()) ? obs_busy[i] : 1'bx;
   endfunction

   // Reference model: expected line symbols for the payload in pay[]
   task automatic model_frame();
      int  n;
      bit  bad;
      n   = pay.size();
      bad = ((n > 255) ? 255 : n) != PKT_WORDS;
      exp_d.delete(); exp_k.delete(); exp_le.delete();
      exp_d.push_back(K_SOF); exp_k.push_back(KI_SOF); exp_le.push_back(1'b0);
      foreach (pay[i]) begin
         exp_d.push_back(pay[i]); exp_k.push_back(KI_DATA);
         exp_le.push_back(1'b0);
      end
      exp_d.push_back(K_EOF); exp_k.push_back(KI_EOF); exp_le.push_back(bad);
      for (int i = 0; i < MIN_IDLE; i++) begin
         exp_d.push_back(K_IDLE); exp_k.push_back(KI_IDLE);
         exp_le.push_back(1'b0);
      end
      m_pkt = (m_pkt + 1) & 16'hFFFF;
      if (bad && m_lerr < 255) m_lerr++;
   endtask

   // Upstream driver: waits for the grant then streams n random words
   task automatic send_burst(input int n, input int drop_en_at);
      int t = 0;
      logic [15:0] w;
      while (TXACK !== 1'b1 && t < 100) begin
         @(negedge RCLK);
         t++;
      end
      checks++;
      if (t >= 100) begin
         fails++;
         $display("FAIL txack_wait: TXACK=%b after %0d cycles, required 1", TXACK, t);
         return;
      end
      pay.delete();
      for (int i = 0; i < n; i++) begin
         w = 16'($urandom);
         pay.push_back(w);
         TXD     = w;
         TXD_VLD = 1'b1;
         if (i == drop_en_at) TX_EN = 1'b0;
         @(negedge RCLK);
      end
      TXD_VLD = 1'b0;
   endtask

   task automatic test_reset();
      int first_ack = -1;
      int bad_idle  = 0;
      RST = 1'b1; TX_EN = 1'b1; TXD_VLD = 1'b0; TXD = 16'h0;
      #1;
      checks++;
      if (GTX_TXDATA !== K_IDLE || GTX_TXCHARISK !== KI_IDLE) begin
         fails++;
         $display("FAIL reset_line: got %h/%b required %h/%b",
                  GTX_TXDATA, GTX_TXCHARISK, K_IDLE, KI_IDLE);
      end
      checks++;
      if ({TXACK, BUSY, LEN_ERR, PKT_CNT, LEN_ERR_CNT} !== 27'd0) begin
         fails++;
         $display("FAIL reset_ctrl: ack=%b busy=%b le=%b pkt=%h lcnt=%h required all 0",
                  TXACK, BUSY, LEN_ERR, PKT_CNT, LEN_ERR_CNT);
      end
      @(negedge RCLK); @(negedge RCLK);
      RST = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge RCLK);
         if (GTX_TXDATA !== K_IDLE || GTX_TXCHARISK !== KI_IDLE) bad_idle++;
         if (BUSY !== 1'b0) bad_idle++;
         if (TXACK === 1'b1 && first_ack < 0) first_ack = c;
      end
      checks++;
      if (first_ack != MIN_IDLE + 1) begin
         fails++;
         $display("FAIL reset_gap: TXACK after %0d idles, required %0d",
                  first_ack - 1, MIN_IDLE);
      end
      checks++;
      if (bad_idle != 0) begin
         fails++;
         $display("FAIL reset_idle: %0d non-idle/busy samples, required 0", bad_idle);
      end
   endtask

   task automatic test_length_check();
      int lens[4] = '{100, 99, 300, 1};
      int s, n;
      foreach (lens[t]) begin
         n = lens[t];
         clear_obs();
         send_burst(n, -1);
         repeat (MIN_IDLE + 6) @(negedge RCLK);
         model_frame();
         s = find_sym(K_SOF, KI_SOF, 0);
         checks++;
         if (s < 0) begin
            fails++;
            $display("FAIL len%0d_sof: no SOF seen, required one", n);
         end else begin
            foreach (exp_d[j]) begin
               checks++;
               if (get_d(s+j) !== exp_d[j] || get_k(s+j) !== exp_k[j] ||
                   get_le(s+j) !== exp_le[j] || get_ack(s+j) !== 1'b0) begin
                  fails++;
                  $display("FAIL len%0d_sym%0d: got %h/%b le=%b ack=%b required %h/%b le=%b ack=0",
                           n, j, get_d(s+j), get_k(s+j), get_le(s+j), get_ack(s+j),
                           exp_d[j], exp_k[j], exp_le[j]);
               end
            end
            checks++;
            if (get_busy(s) !== 1'b1 || get_busy(s+n+1+MIN_IDLE) !== 1'b1 || BUSY !== 1'b0) begin
               fails++;
               $display("FAIL len%0d_busy: sof=%b last_idle=%b now=%b required 1/1/0",
                        n, get_busy(s), get_busy(s+n+1+MIN_IDLE), BUSY);
            end
         end
         checks++;
         if (PKT_CNT !== 16'(m_pkt) || LEN_ERR_CNT !== 8'(m_lerr)) begin
            fails++;
            $display("FAIL len%0d_cnt: pkt=%0d lerr=%0d required %0d/%0d",
                     n, PKT_CNT, LEN_ERR_CNT, m_pkt, m_lerr);
         end
      end
   endtask

   task automatic test_tx_en_drop();
      int s, bad = 0;
      clear_obs();
      send_burst(PKT_WORDS, 50);
      repeat (MIN_IDLE + 6) @(negedge RCLK);
      model_frame();
      s = find_sym(K_SOF, KI_SOF, 0);
      foreach (exp_d[j])
         if (get_d(s+j) !== exp_d[j] || get_k(s+j) !== exp_k[j]) bad++;
      checks++;
      if (s < 0 || bad != 0) begin
         fails++;
         $display("FAIL txen_frame: sof_at=%0d bad_symbols=%0d required 0", s, bad);
      end
      bad = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge RCLK);
         if (TXACK !== 1'b0 || GTX_TXDATA !== K_IDLE) bad++;
      end
      checks++;
      if (bad != 0) begin
         fails++;
         $display("FAIL txen_hold: %0d cycles with ack or non-idle, required 0", bad);
      end
      TX_EN = 1'b1;
      @(negedge RCLK); @(negedge RCLK);
      checks++;
      if (TXACK !== 1'b1) begin
         fails++;
         $display("FAIL txen_regrant: TXACK=%b required 1", TXACK);
      end
   endtask

   task automatic test_gap_drop();
      int s, e, bad = 0;
      clear_obs();
      send_burst(PKT_WORDS, -1);
      @(negedge RCLK); @(negedge RCLK);
      for (int c = 0; c < 4; c++) begin
         TXD = 16'hDEA0 + 16'(c);
         TXD_VLD = 1'b1;
         @(negedge RCLK);
      end
      TXD_VLD = 1'b0;
      repeat (20) @(negedge RCLK);
      model_frame();
      s = find_sym(K_SOF, KI_SOF, 0);
      foreach (exp_d[j])
         if (get_d(s+j) !== exp_d[j] || get_k(s+j) !== exp_k[j]) bad++;
      checks++;
      if (s < 0 || bad != 0) begin
         fails++;
         $display("FAIL gap_frame: sof_at=%0d bad_symbols=%0d required 0", s, bad);
      end
      e = find_sym(K_EOF, KI_EOF, 0);
      checks++;
      if (e < 0 || find_sym(K_SOF, KI_SOF, e) >= 0) begin
         fails++;
         $display("FAIL gap_drop: eof_at=%0d sof_after=%0d required no SOF",
                  e, find_sym(K_SOF, KI_SOF, (e < 0) ? 0 : e));
      end
      checks++;
      if (PKT_CNT !== 16'(m_pkt)) begin
         fails++;
         $display("FAIL gap_cnt: pkt=%0d required %0d", PKT_CNT, m_pkt);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] b[$];
      int t = 0, e, s2, bad = 0;
      clear_obs();
      send_burst(PKT_WORDS, -1);
      model_frame();
      @(negedge RCLK);
      for (int i = 0; i < PKT_WORDS; i++) b.push_back(16'($urandom));
      TXD = b[0];
      TXD_VLD = 1'b1;
      do begin
         @(negedge RCLK);
         t++;
      end while (!(GTX_TXDATA === K_SOF && GTX_TXCHARISK === KI_SOF) && t < 40);
      checks++;
      if (t >= 40) begin
         fails++;
         $display("FAIL b2b_sof_wait: no second SOF after %0d cycles", t);
      end
      for (int i = 1; i < PKT_WORDS; i++) begin
         TXD = b[i];
         @(negedge RCLK);
      end
      TXD_VLD = 1'b0;
      repeat (MIN_IDLE + 6) @(negedge RCLK);
      e  = find_sym(K_EOF, KI_EOF, 0);
      s2 = find_sym(K_SOF, KI_SOF, (e < 0) ? 0 : e);
      for (int i = e + 1; i < s2; i++)
         if (get_d(i) !== K_IDLE || get_k(i) !== KI_IDLE) bad++;
      checks++;
      if (e < 0 || s2 - e - 1 != MIN_IDLE || bad != 0) begin
         fails++;
         $display("FAIL b2b_gap: %0d symbols between EOF and SOF (%0d non-idle), required %0d idles",
                  s2 - e - 1, bad, MIN_IDLE);
      end
      pay = b;
      model_frame();
      bad = 0;
      foreach (exp_d[j])
         if (get_d(s2+j) !== exp_d[j] || get_k(s2+j) !== exp_k[j]) bad++;
      checks++;
      if (s2 < 0 || bad != 0) begin
         fails++;
         $display("FAIL b2b_frame2: bad_symbols=%0d required 0", bad);
      end
      checks++;
      if (PKT_CNT !== 16'(m_pkt)) begin
         fails++;
         $display("FAIL b2b_cnt: pkt=%0d required %0d", PKT_CNT, m_pkt);
      end
   endtask

   task automatic test_pkt_wrap();
      @(negedge RCLK);
      force dut.pkt_cnt_q = 16'hFFFF;
      #1;
      release dut.pkt_cnt_q;
      m_pkt = 16'hFFFF;
      send_burst(PKT_WORDS, -1);
      repeat (MIN_IDLE + 6) @(negedge RCLK);
      model_frame();
      checks++;
      if (PKT_CNT !== 16'(m_pkt) || PKT_CNT !== 16'h0000) begin
         fails++;
         $display("FAIL pkt_wrap: pkt=%h required %h", PKT_CNT, 16'(m_pkt));
      end
   endtask

   task automatic test_reset_midpkt();
      int t = 0;
      while (TXACK !== 1'b1 && t < 100) begin
         @(negedge RCLK);
         t++;
      end
      for (int i = 0; i < 40; i++) begin
         TXD = 16'($urandom);
         TXD_VLD = 1'b1;
         @(negedge RCLK);
      end
      #2;
      RST = 1'b1;
      #1;
      checks++;
      if (GTX_TXDATA !== K_IDLE || GTX_TXCHARISK !== KI_IDLE) begin
         fails++;
         $display("FAIL rst_async_line: got %h/%b required %h/%b",
                  GTX_TXDATA, GTX_TXCHARISK, K_IDLE, KI_IDLE);
      end
      checks++;
      if (PKT_CNT !== 16'd0 || LEN_ERR_CNT !== 8'd0 || BUSY !== 1'b0) begin
         fails++;
         $display("FAIL rst_async_cnt: pkt=%h lcnt=%h busy=%b required 0/0/0",
                  PKT_CNT, LEN_ERR_CNT, BUSY);
      end
      TXD_VLD = 1'b0;
      m_pkt = 0;
      m_lerr = 0;
      @(negedge RCLK);
      RST = 1'b0;
      clear_obs();
      repeat (20) @(negedge RCLK);
      checks++;
      if (find_sym(K_EOF, KI_EOF, 0) >= 0 || PKT_CNT !== 16'(m_pkt)) begin
         fails++;
         $display("FAIL rst_no_eof: eof_at=%0d pkt=%0d required none/0",
                  find_sym(K_EOF, KI_EOF, 0), PKT_CNT);
      end
   endtask

   initial begin
      test_reset();
      test_length_check();
      test_tx_en_drop();
      test_gap_drop();
      test_back_to_back();
      test_pkt_wrap();
      test_reset_midpkt();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
